periph_bus_arbiter: RTL and testbench
=====================================

# periph_bus_arbiter

Two-master arbiter for the memory-mapped peripheral register bus (timer TH/TL/TCON, LEDs, switches, digits, UART at 0x40000000–0x40000020). It sits between the peripheral block and its two requesters, the CPU data port (master 0) and the debug/DMA port (master 1). It grants the single rd/wr/addr/wdata port to one master at a time, in round-robin order with an optional bounded bus lock, and returns registered read data and a completion pulse.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LOCK_MAX, 4, maximum consecutive locked grants to one master while the other is requesting (≥1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  request, level
- m0_wr, m1_wr  in  1  1 = write, 0 = read
- m0_lock, m1_lock  in  1  retain ownership for the next transaction
- m0_addr, m1_addr  in  ADDR_W  target address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  one-cycle pulse: command captured
- m0_done, m1_done  out  1  one-cycle pulse: transaction complete
- m0_rdata, m1_rdata  out  DATA_W  registered read result, held until the next read by that master
- p_rd, p_wr  out  1  peripheral strobes
- p_addr  out  ADDR_W  peripheral address
- p_wdata  out  DATA_W  peripheral write data
- p_rdata  in  DATA_W  peripheral read data (combinational from p_rd/p_addr)

## Operation
- The FSM has two states, IDLE and XFER. Reset enters IDLE.
- **IDLE, no req:** stay in IDLE. All p_* outputs are 0.
- **IDLE, any eligible req (arbitration edge):**
  - Pick the winner.
  - Latch its wr, addr, wdata and lock into the command registers.
  - Pulse the winner's gnt in the following cycle.
  - Go to XFER.
- **XFER (exactly 1 cycle):**
  - Drive p_addr/p_wdata from the command registers.
  - Drive p_rd = ~wr and p_wr = wr.
  - On the closing edge, capture p_rdata into the winner's rdata (reads only; writes leave rdata unchanged).
  - Pulse the winner's done in the next cycle.
  - Return to IDLE.
- **Round-robin:**
  - A last-winner pointer is updated at each grant; its reset value is 1.
  - On a simultaneous request, the master that is not last-winner wins, so m0 wins first after reset.
  - A lone requester always wins, unless masked by a lock.
- **Lock:**
  - If the latched lock = 1, the other master is masked at the next arbitration.
  - A lock counter increments on each locked grant to the same owner. It clears on an unlocked grant or an owner change.
  - When the counter reaches LOCK_MAX and the other master is requesting, the lock is ignored for one arbitration and the other master wins.
  - If the lock owner is not requesting at an arbitration edge, the lock is released.
- **Request protocol:**
  - A master holds req, wr, addr, wdata and lock stable until it sees gnt.
  - req is re-sampled only in IDLE. A master that keeps req high after gnt issues a new transaction with its current command.
- Only one transaction is outstanding at a time. gnt and done are never asserted to both masters in the same cycle.

## Timing
- **Reset values:** FSM = IDLE; all gnt, done, p_rd, p_wr = 0; p_addr, p_wdata, m*_rdata = 0; last-winner = 1; lock counter = 0.
- **Latency:** req high before edge N (IDLE) → gnt and p_* valid in cycle N+1 → rdata valid and done = 1 in cycle N+2.
- **Throughput:** a master that holds req gets back-to-back transactions every 2 cycles.
- **Write timing:** the peripheral write takes effect at the edge closing the XFER cycle (N+1→N+2).
- **Reset mid-XFER:** the transaction is aborted with no done, no rdata update, and p_* = 0 immediately (asynchronous).
- **Request during XFER:** a req rising during XFER is arbitrated at the edge after returning to IDLE.

## Test plan
- **Reset:** apply reset with random inputs → all outputs 0. After release, m0 reads 0x40000010 with p_rdata=0x000000A5 → m0_gnt in cycle 1, p_rd=1 and p_addr=0x40000010 in cycle 1, m0_done with m0_rdata=0xA5 in cycle 2.
- **Simultaneous requests:** m0 and m1 request together continuously → grants alternate m0, m1, m0, m1. gnt and done are never asserted together for both masters; one transaction every 2 cycles.
- **Write:** m1 writes 0x00000003 to 0x40000008 → p_wr=1 and p_wdata=3 for exactly 1 cycle. m1_rdata is unchanged and m1_done pulses once.
- **Lock starvation bound:** m0 requests with lock=1, m1 requesting constantly, LOCK_MAX=4 → m0 gets 5 consecutive grants (1 initial + 4 locked), then m1 wins. With m0 lock=0, strict alternation.
- **Reset mid-operation:** assert reset during XFER of an m0 read → no m0_done, m0_rdata remains 0, p_rd drops without waiting for a clock edge. After release, the first simultaneous request goes to m0.

Source files
------------

// File: rtl/periph_bus_arbiter_if.sv
// Two-master peripheral register bus: master request/response signals plus the
// single arbitrated peripheral port.
interface periph_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req,   m1_req;
  logic              m0_wr,    m1_wr;
  logic              m0_lock,  m1_lock;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt,   m1_gnt;
  logic              m0_done,  m1_done;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              p_rd,     p_wr;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;

  // Arbiter side
  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_lock, m1_lock,
           m0_addr, m1_addr, m0_wdata, m1_wdata, p_rdata,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           p_rd, p_wr, p_addr, p_wdata
  );

  // Requesters plus peripheral side
  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_lock, m1_lock,
           m0_addr, m1_addr, m0_wdata, m1_wdata, p_rdata,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           p_rd, p_wr, p_addr, p_wdata
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Round-robin two-master arbiter for the peripheral register bus with a
// bounded bus lock; one transaction outstanding, registered gnt/done/rdata.
module periph_bus_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 4
) (
  input logic            clk,
  input logic            reset,
  periph_bus_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state;
  logic               last_winner;  // 0 = m0, 1 = m1; also the current owner during XFER
  logic               cmd_lock;
  logic [CNT_W-1:0]   lock_cnt;

  logic arb_valid_c;
  logic arb_win_c;
  logic owner_req_c;
  logic other_req_c;
  logic locked_grant_c;

  // Winner selection: a held lock beats round-robin until the counter hits its bound
  always_comb begin
    arb_valid_c = bus.m0_req | bus.m1_req;
    owner_req_c = last_winner ? bus.m1_req : bus.m0_req;
    other_req_c = last_winner ? bus.m0_req : bus.m1_req;
    arb_win_c   = bus.m1_req;
    if (cmd_lock && owner_req_c) begin
      if (other_req_c && (lock_cnt == CNT_W'(LOCK_MAX)))
        arb_win_c = ~last_winner;
      else
        arb_win_c = last_winner;
    end else if (bus.m0_req && bus.m1_req) begin
      arb_win_c = ~last_winner;
    end
    locked_grant_c = cmd_lock && owner_req_c && (arb_win_c == last_winner);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_winner  <= 1'b1;
      cmd_lock     <= 1'b0;
      lock_cnt     <= '0;
      bus.m0_gnt   <= 1'b0;
      bus.m1_gnt   <= 1'b0;
      bus.m0_done  <= 1'b0;
      bus.m1_done  <= 1'b0;
      bus.m0_rdata <= DATA_W'(0);
      bus.m1_rdata <= DATA_W'(0);
      bus.p_rd     <= 1'b0;
      bus.p_wr     <= 1'b0;
      bus.p_addr   <= ADDR_W'(0);
      bus.p_wdata  <= DATA_W'(0);
    end else begin
      bus.m0_gnt  <= 1'b0;
      bus.m1_gnt  <= 1'b0;
      bus.m0_done <= 1'b0;
      bus.m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid_c) begin
            state       <= XFER;
            last_winner <= arb_win_c;
            cmd_lock    <= arb_win_c ? bus.m1_lock : bus.m0_lock;
            if (!locked_grant_c)
              lock_cnt <= '0;
            else if (lock_cnt != CNT_W'(LOCK_MAX))
              lock_cnt <= lock_cnt + CNT_W'(1);
            bus.m0_gnt  <= ~arb_win_c;
            bus.m1_gnt  <= arb_win_c;
            bus.p_wr    <= arb_win_c ? bus.m1_wr : bus.m0_wr;
            bus.p_rd    <= arb_win_c ? ~bus.m1_wr : ~bus.m0_wr;
            bus.p_addr  <= arb_win_c ? bus.m1_addr : bus.m0_addr;
            bus.p_wdata <= arb_win_c ? bus.m1_wdata : bus.m0_wdata;
          end
        end
        XFER: begin
          state       <= IDLE;
          bus.p_rd    <= 1'b0;
          bus.p_wr    <= 1'b0;
          bus.p_addr  <= ADDR_W'(0);
          bus.p_wdata <= DATA_W'(0);
          bus.m0_done <= ~last_winner;
          bus.m1_done <= last_winner;
          // Read data lands only for reads; writes leave the holding register alone
          if (bus.p_rd) begin
            if (last_winner) bus.m1_rdata <= bus.p_rdata;
            else             bus.m0_rdata <= bus.p_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: vector table for single transactions
// and round-robin, hand sequences for lock bound and asynchronous reset.
module tb_periph_bus_arbiter;

  localparam int unsigned OUT_W = 134;
  localparam logic [31:0] A00 = 32'h4000_0000;
  localparam logic [31:0] A08 = 32'h4000_0008;
  localparam logic [31:0] A10 = 32'h4000_0010;
  localparam logic [31:0] Z   = 32'h0;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  periph_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral register file stub: combinational read, write at the closing edge
  logic [31:0] regs [0:15];
  assign bus.p_rdata = bus.p_rd ? regs[bus.p_addr[5:2]] : 32'h0;
  always @(posedge clk) if (bus.p_wr) regs[bus.p_addr[5:2]] <= bus.p_wdata;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  gnt, done;   // {m0, m1}
    logic        prd, pwr;
    logic [31:0] pa, pd, rd0, rd1;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [OUT_W-1:0] pack_out();
    return {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.p_rd, bus.p_wr,
            bus.p_addr, bus.p_wdata, bus.m0_rdata, bus.m1_rdata};
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic l0, input logic l1, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.m0_req = r0;   bus.m1_req = r1;
    bus.m0_wr = w0;    bus.m1_wr = w1;
    bus.m0_lock = l0;  bus.m1_lock = l1;
    bus.m0_addr = a0;  bus.m1_addr = a1;
    bus.m0_wdata = d0; bus.m1_wdata = d1;
  endtask

  // Collect n grants; flags both-master gnt/done and spacing other than 2 cycles
  task automatic watch(input int n, input string tag, output logic [15:0] seq);
    int got = 0;
    int last_c = -1;
    int conflicts = 0;
    int spacing = 0;
    seq = '0;
    for (int c = 0; c < 4 * n + 8 && got < n; c++) begin
      @(negedge clk);
      if ((bus.m0_gnt && bus.m1_gnt) || (bus.m0_done && bus.m1_done)) conflicts++;
      if (bus.m0_gnt || bus.m1_gnt) begin
        seq[got] = bus.m1_gnt;
        if (last_c >= 0 && c - last_c != 2) spacing++;
        last_c = c;
        got++;
      end
    end
    check({tag, " grant_count"}, OUT_W'(got), OUT_W'(n));
    check({tag, " both_masters"}, OUT_W'(conflicts), OUT_W'(0));
    check({tag, " spacing"}, OUT_W'(spacing), OUT_W'(0));
  endtask

  initial begin
    logic [15:0] seq;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[0] = 32'h11;
    regs[4] = 32'hA5;

    //            r0    r1    w0    w1    a0   a1   d0 d1      gnt    done  prd   pwr   pa   pd       rd0       rd1
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, A10, A00, Z, Z,     2'b10, 2'b00, 1'b1, 1'b0, A10, Z,       Z,        Z};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, A10, A00, Z, Z,     2'b00, 2'b10, 1'b0, 1'b0, Z,   Z,       32'hA5,   Z};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, A10, A00, Z, Z,     2'b00, 2'b00, 1'b0, 1'b0, Z,   Z,       32'hA5,   Z};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, A00, A08, Z, 32'h3, 2'b01, 2'b00, 1'b0, 1'b1, A08, 32'h3,   32'hA5,   Z};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, A00, A08, Z, Z,     2'b00, 2'b01, 1'b0, 1'b0, Z,   Z,       32'hA5,   Z};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, A00, A08, Z, Z,     2'b01, 2'b00, 1'b1, 1'b0, A08, Z,       32'hA5,   Z};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, A00, A08, Z, Z,     2'b00, 2'b01, 1'b0, 1'b0, Z,   Z,       32'hA5,   32'h3};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, A00, A08, Z, Z,     2'b10, 2'b00, 1'b1, 1'b0, A00, Z,       32'hA5,   32'h3};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, A00, A08, Z, Z,     2'b00, 2'b10, 1'b0, 1'b0, Z,   Z,       32'h11,   32'h3};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, A00, A08, Z, Z,     2'b01, 2'b00, 1'b1, 1'b0, A08, Z,       32'h11,   32'h3};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, A00, A08, Z, Z,     2'b00, 2'b01, 1'b0, 1'b0, Z,   Z,       32'h11,   32'h3};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, A00, A08, Z, Z,     2'b10, 2'b00, 1'b1, 1'b0, A00, Z,       32'h11,   32'h3};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, A00, A08, Z, Z,     2'b00, 2'b10, 1'b0, 1'b0, Z,   Z,       32'h11,   32'h3};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, A00, A08, Z, Z,     2'b01, 2'b00, 1'b1, 1'b0, A08, Z,       32'h11,   32'h3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, A00, A08, Z, Z,     2'b00, 2'b01, 1'b0, 1'b0, Z,   Z,       32'h11,   32'h3};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, A00, A08, Z, Z,     2'b00, 2'b00, 1'b0, 1'b0, Z,   Z,       32'h11,   32'h3};

    // Reset held with random requests: everything stays quiet
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      @(negedge clk);
      check($sformatf("reset_outputs_%0d", i), pack_out(), OUT_W'(0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, Z, Z);
    reset = 1'b1;

    // Single reads/writes and round-robin from the vector table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, 1'b0, 1'b0,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      @(negedge clk);
      check($sformatf("vec_%0d", i), pack_out(),
            {vecs[i].gnt, vecs[i].done, vecs[i].prd, vecs[i].pwr,
             vecs[i].pa, vecs[i].pd, vecs[i].rd0, vecs[i].rd1});
    end

    // Lock bound: m0 locking against a constantly requesting m1
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, A00, A08, Z, Z);
    watch(6, "lock", seq);
    check("lock_order", OUT_W'(seq[5:0]), OUT_W'(6'b100000));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A00, A08, Z, Z);
    repeat (3) @(negedge clk);

    // Without lock both requesters alternate strictly
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A00, A08, Z, Z);
    watch(4, "nolock", seq);
    check("nolock_order", OUT_W'(seq[3:0]), OUT_W'(4'b1010));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A00, A08, Z, Z);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of an m0 read
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A10, A08, Z, Z);
    @(negedge clk);
    check("midrst_xfer_active", OUT_W'({bus.m0_gnt, bus.p_rd}), OUT_W'(2'b11));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A10, A08, Z, Z);
    #1 reset = 1'b0;
    #1 check("midrst_immediate", pack_out(), OUT_W'(0));
    @(negedge clk);
    check("midrst_held", pack_out(), OUT_W'(0));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_no_done", pack_out(), OUT_W'(0));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A10, A08, Z, Z);
    @(negedge clk);
    check("midrst_first_gnt", OUT_W'({bus.m0_gnt, bus.m1_gnt}), OUT_W'(2'b10));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A10, A08, Z, Z);
    @(negedge clk);
    check("midrst_done_rdata", OUT_W'({bus.m0_done, bus.m0_rdata}), OUT_W'({1'b1, 32'hA5}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
